// File: rtl/intersection_pkg.sv
// Shared types and default dwell times for the actuated intersection sequencer.
package intersection_pkg;

    localparam int CNT_W = 12;

    typedef logic [CNT_W-1:0] count_t;

    typedef enum logic [2:0] {
        ST_CLR_A = 3'd0,
        ST_G1    = 3'd1,
        ST_Y1    = 3'd2,
        ST_CLR_B = 3'd3,
        ST_WALK  = 3'd4,
        ST_G2    = 3'd5,
        ST_Y2    = 3'd6
    } state_t;

    localparam int T_CLR_DEF    = 50;
    localparam int T_Y_DEF      = 250;
    localparam int T_G1_MIN_DEF = 500;
    localparam int T_G2_DEF     = 2250;
    localparam int T_WALK_DEF   = 500;

endpackage

// File: rtl/request_latch.sv
// Sticky request flag: set by a request level, cleared while its phase is being served.
module request_latch (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic hold_clr,
    output logic pend
);

    // Clear has priority over set so a request held through service does not survive it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend <= 1'b0;
        end else if (hold_clr) begin
            pend <= 1'b0;
        end else if (req) begin
            pend <= 1'b1;
        end
    end

endmodule

// File: rtl/intersection_sequencer.sv
// Actuated phase sequencer: road 1 rests in green, road 2 and the walk phase run on demand.
module intersection_sequencer
    import intersection_pkg::*;
#(
    parameter int T_CLR    = T_CLR_DEF,
    parameter int T_Y      = T_Y_DEF,
    parameter int T_G1_MIN = T_G1_MIN_DEF,
    parameter int T_G2     = T_G2_DEF,
    parameter int T_WALK   = T_WALK_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic car_req,
    input  logic ped_req,
    output logic red1,
    output logic yellow1,
    output logic green1,
    output logic red2,
    output logic yellow2,
    output logic green2,
    output logic walk,
    output logic ped_wait
);

    localparam count_t CLR_END  = count_t'(T_CLR);
    localparam count_t Y_END    = count_t'(T_Y);
    localparam count_t G1_MIN   = count_t'(T_G1_MIN);
    localparam count_t G2_END   = count_t'(T_G2);
    localparam count_t WALK_END = count_t'(T_WALK);
    localparam count_t ONE      = count_t'(1);

    state_t state;
    state_t next_state;
    count_t count;
    logic   ped_pend;
    logic   car_pend;

    // Pends are cleared on the edge that enters their service phase, so the
    // indicator is already dark in the first cycle of that phase and a held
    // request reappears in the first cycle after it.
    request_latch u_ped_latch (
        .clk      (clk),
        .reset    (reset),
        .req      (ped_req),
        .hold_clr (next_state == ST_WALK),
        .pend     (ped_pend)
    );

    request_latch u_car_latch (
        .clk      (clk),
        .reset    (reset),
        .req      (car_req),
        .hold_clr (next_state == ST_G2),
        .pend     (car_pend)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_CLR_A;
        end else begin
            state <= next_state;
        end
    end

    // Phase counter: restarts at 1 on every state change, holds once G1 has met its minimum.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= ONE;
        end else if (next_state != state) begin
            count <= ONE;
        end else if (state == ST_G1 && count >= G1_MIN) begin
            count <= count;
        end else begin
            count <= count + ONE;
        end
    end

    // Next-state selection from the current dwell count and latched calls.
    always_comb begin
        next_state = state;
        case (state)
            ST_CLR_A: if (count == CLR_END) next_state = ST_G1;
            ST_G1:    if (count >= G1_MIN && (car_pend || ped_pend)) next_state = ST_Y1;
            ST_Y1:    if (count == Y_END) next_state = ST_CLR_B;
            ST_CLR_B: if (count == CLR_END) next_state = ped_pend ? ST_WALK : ST_G2;
            ST_WALK:  if (count == WALK_END) next_state = car_pend ? ST_G2 : ST_G1;
            ST_G2:    if (count == G2_END) next_state = ST_Y2;
            ST_Y2:    if (count == Y_END) next_state = ST_CLR_A;
            default:  next_state = ST_CLR_A;
        endcase
    end

    // Lamp decode from the registered state; one lamp per road is always lit.
    always_comb begin
        red1    = 1'b1;
        yellow1 = 1'b0;
        green1  = 1'b0;
        red2    = 1'b1;
        yellow2 = 1'b0;
        green2  = 1'b0;
        walk    = 1'b0;
        case (state)
            ST_G1: begin
                red1   = 1'b0;
                green1 = 1'b1;
            end
            ST_Y1: begin
                red1    = 1'b0;
                yellow1 = 1'b1;
            end
            ST_WALK: begin
                walk = 1'b1;
            end
            ST_G2: begin
                red2   = 1'b0;
                green2 = 1'b1;
            end
            ST_Y2: begin
                red2    = 1'b0;
                yellow2 = 1'b1;
            end
            default: begin
                red1 = 1'b1;
                red2 = 1'b1;
            end
        endcase
    end

    assign ped_wait = ped_pend;

endmodule
